// File: rtl/dm_write_handler.sv
// Data-memory write handler: serialises one store into little-endian byte writes.
// Optional misalignment trap enabled by defining DM_WR_ALIGN_CHECK_EN.
module dm_write_handler #(
  parameter int DOUBLEWORD_WIDTH = 64,
  parameter int DATA_MEMORY_SIZE = 1024,
  parameter int ADDR_WIDTH_DM    = $clog2(DATA_MEMORY_SIZE),
  parameter int DATA_TYPE_WIDTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DOUBLEWORD_WIDTH-1:0] data_bus_wr,
  input  logic [ADDR_WIDTH_DM-1:0]    addr_wr,
  input  logic [DATA_TYPE_WIDTH-1:0]  data_type_wr,
  input  logic                        wr_ins,
  output logic                        wr_idle,
  output logic                        mem_wr_en,
  output logic [ADDR_WIDTH_DM-1:0]    mem_addr,
`ifdef DM_WR_ALIGN_CHECK_EN
  output logic                        wr_misaligned,
`endif
  output logic [7:0]                  mem_wdata
);

  localparam int AW    = ADDR_WIDTH_DM;
  localparam int DW    = DOUBLEWORD_WIDTH;
  localparam int LEN_W = $clog2(DW/8) + 1;
  localparam logic [AW:0] MSZ = (AW+1)'(DATA_MEMORY_SIZE);

`ifdef DM_WR_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    ERR   = 2'b10
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [AW-1:0]     base_q, base_d;
  logic [DW-1:0]     sh_q, sh_d;
  logic [LEN_W-1:0]  req_len;
  logic [AW:0]       sum;
  logic [AW:0]       wrapped;

  assign req_len = LEN_W'(1) << data_type_wr;

`ifdef DM_WR_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic req_mis;

  assign req_mis = |(addr_wr & AW'(req_len - LEN_W'(1)));
  assign wr_misaligned = mis_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      sh_q    <= '0;
`ifdef DM_WR_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      base_q  <= base_d;
      sh_q    <= sh_d;
`ifdef DM_WR_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    base_d  = base_q;
    sh_d    = sh_q;
`ifdef DM_WR_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      IDLE: begin
        if (wr_ins) begin
          base_d  = addr_wr;
          sh_d    = data_bus_wr;
          len_d   = req_len;
          cnt_d   = '0;
          state_d = WRITE;
`ifdef DM_WR_ALIGN_CHECK_EN
          if (req_mis) begin
            state_d = ERR;
            mis_d   = 1'b1;
          end
`endif
        end
      end
      WRITE: begin
        sh_d  = sh_q >> 8;
        cnt_d = cnt_q + LEN_W'(1);
        if (cnt_q == len_q - LEN_W'(1))
          state_d = IDLE;
      end
`ifdef DM_WR_ALIGN_CHECK_EN
      ERR: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Address wraps modulo the memory size, not just the address width.
  assign sum     = {1'b0, base_q} + (AW+1)'(cnt_q);
  assign wrapped = (sum >= MSZ) ? sum - MSZ : sum;

  assign wr_idle   = (state_q == IDLE);
  assign mem_wr_en = (state_q == WRITE);
  assign mem_addr  = mem_wr_en ? AW'(wrapped) : '0;
  assign mem_wdata = mem_wr_en ? sh_q[7:0] : 8'h00;

endmodule

// File: tb/tb_dm_write_handler.sv
// Self-checking bench for dm_write_handler with a queue-based byte-write model.
// Misalignment checks compile in when DM_WR_ALIGN_CHECK_EN is defined.
module tb_dm_write_handler;

  logic        clk;
  logic        rst_n;
  logic [63:0] data_bus_wr;
  logic [9:0]  addr_wr;
  logic [1:0]  data_type_wr;
  logic        wr_ins;
  logic        wr_idle;
  logic        mem_wr_en;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
`ifdef DM_WR_ALIGN_CHECK_EN
  logic        wr_misaligned;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cap = 0;

  logic [9:0] obs_a[$];
  logic [7:0] obs_d[$];
  int         obs_c[$];

  dm_write_handler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_bus_wr  (data_bus_wr),
    .addr_wr      (addr_wr),
    .data_type_wr (data_type_wr),
    .wr_ins       (wr_ins),
    .wr_idle      (wr_idle),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
`ifdef DM_WR_ALIGN_CHECK_EN
    .wr_misaligned(wr_misaligned),
`endif
    .mem_wdata    (mem_wdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_wr_en === 1'b1) begin
      obs_a.push_back(mem_addr);
      obs_d.push_back(mem_wdata);
      obs_c.push_back(cyc);
    end
  end

  function automatic logic [7:0] exp_byte(input logic [63:0] d, input int k);
    logic [63:0] s;
    s = d >> (8 * k);
    return s[7:0];
  endfunction

  function automatic logic [9:0] exp_addr(input logic [9:0] a, input int k);
    int s;
    s = (int'(a) + k) % 1024;
    return s[9:0];
  endfunction

  task automatic clear_obs();
    obs_a.delete();
    obs_d.delete();
    obs_c.delete();
  endtask

  task automatic wait_idle(output int busy);
    busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wr_idle === 1'b1) break;
      busy++;
    end
    if (busy >= 30) begin
      errors++;
      $display("FAIL idle_timeout: busy %0d cycles, want < 30", busy);
    end
  endtask

  task automatic send(input logic [9:0] a, input logic [63:0] d,
                      input logic [1:0] dt, output int busy);
    @(posedge clk); #1;
    addr_wr = a;
    data_bus_wr = d;
    data_type_wr = dt;
    wr_ins = 1'b1;
    clear_obs();
    @(posedge clk); #1;
    cap = cyc;
    wr_ins = 1'b0;
    wait_idle(busy);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_ins = 1'b0;
    addr_wr = '0;
    data_bus_wr = '0;
    data_type_wr = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_idle !== 1'b1 || mem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_hs: idle=%b en=%b want 1 0", wr_idle, mem_wr_en);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_idle !== 1'b1) begin
      errors++;
      $display("FAIL rst_idle: got %b want 1", wr_idle);
    end
    checks++;
    if (mem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_en: got %b want 0", mem_wr_en);
    end
    checks++;
    if (mem_addr !== 10'h0 || mem_wdata !== 8'h0) begin
      errors++;
      $display("FAIL rst_bus: addr=%h data=%h want 0 0", mem_addr, mem_wdata);
    end
`ifdef DM_WR_ALIGN_CHECK_EN
    checks++;
    if (wr_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL rst_mis: got %b want 0", wr_misaligned);
    end
`endif
  endtask

  task automatic test_byte();
    int busy;
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[7:0] = 8'hA5;
    send(10'h010, d, 2'b00, busy);
    checks++;
    if (busy != 1) begin
      errors++;
      $display("FAIL byte_busy: got %0d want 1", busy);
    end
    checks++;
    if (obs_a.size() != 1) begin
      errors++;
      $display("FAIL byte_count: got %0d want 1", obs_a.size());
    end else begin
      checks++;
      if (obs_a[0] !== 10'h010 || obs_d[0] !== 8'hA5) begin
        errors++;
        $display("FAIL byte_wr: got %h@%h want a5@010", obs_d[0], obs_a[0]);
      end
      checks++;
      if (obs_c[0] != cap) begin
        errors++;
        $display("FAIL byte_lat: got cyc %0d want %0d", obs_c[0], cap);
      end
    end
  endtask

  task automatic test_dword_wrap();
    int busy;
    logic [9:0] a;
    logic [63:0] d;
    d = 64'h8877665544332211;
`ifdef DM_WR_ALIGN_CHECK_EN
    a = 10'h3F8;
`else
    a = 10'h3FC;
`endif
    send(a, d, 2'b11, busy);
    checks++;
    if (busy != 8) begin
      errors++;
      $display("FAIL dw_busy: got %0d want 8", busy);
    end
    checks++;
    if (obs_a.size() != 8) begin
      errors++;
      $display("FAIL dw_count: got %0d want 8", obs_a.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (obs_a[k] !== exp_addr(a, k) || obs_d[k] !== exp_byte(d, k)
            || obs_c[k] != cap + k) begin
          errors++;
          $display("FAIL dw_b%0d: got %h@%h c%0d want %h@%h c%0d", k,
                   obs_d[k], obs_a[k], obs_c[k],
                   exp_byte(d, k), exp_addr(a, k), cap + k);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int busy;
    logic [63:0] d;
    d = 64'h00000000DEADBEEF;
    @(posedge clk); #1;
    addr_wr = 10'h020;
    data_bus_wr = d;
    data_type_wr = 2'b10;
    wr_ins = 1'b1;
    clear_obs();
    @(posedge clk); #1;
    cap = cyc;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_idle !== 1'b1 || mem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: idle=%b en=%b want 1 0", wr_idle, mem_wr_en);
    end
    @(posedge clk); #1;
    wr_ins = 1'b0;
    wait_idle(busy);
    checks++;
    if (busy != 4) begin
      errors++;
      $display("FAIL b2b_busy: got %0d want 4", busy);
    end
    checks++;
    if (obs_a.size() != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 8", obs_a.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        int j;
        int c;
        j = k % 4;
        c = (k < 4) ? cap + k : cap + 5 + j;
        checks++;
        if (obs_a[k] !== exp_addr(10'h020, j) || obs_d[k] !== exp_byte(d, j)
            || obs_c[k] != c) begin
          errors++;
          $display("FAIL b2b_b%0d: got %h@%h c%0d want %h@%h c%0d", k,
                   obs_d[k], obs_a[k], obs_c[k],
                   exp_byte(d, j), exp_addr(10'h020, j), c);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [63:0] d;
    d = {$urandom, $urandom};
    @(posedge clk); #1;
    addr_wr = 10'h100;
    data_bus_wr = d;
    data_type_wr = 2'b11;
    wr_ins = 1'b1;
    clear_obs();
    @(posedge clk); #1;
    wr_ins = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (mem_wr_en !== 1'b1 || mem_wdata !== exp_byte(d, 3)) begin
      errors++;
      $display("FAIL abort_pre: en=%b data=%h want 1 %h",
               mem_wr_en, mem_wdata, exp_byte(d, 3));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_wr_en !== 1'b0 || wr_idle !== 1'b1) begin
      errors++;
      $display("FAIL abort_async: en=%b idle=%b want 0 1", mem_wr_en, wr_idle);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_wr_en !== 1'b0 || wr_idle !== 1'b1) begin
        errors++;
        $display("FAIL abort_post%0d: en=%b idle=%b want 0 1",
                 i, mem_wr_en, wr_idle);
      end
    end
    checks++;
    if (obs_a.size() != 3) begin
      errors++;
      $display("FAIL abort_count: got %0d want 3", obs_a.size());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      int busy;
      int len;
      logic [1:0] dt;
      logic [9:0] a;
      logic [63:0] d;
      dt = 2'($urandom_range(0, 3));
      len = 1 << dt;
      a = 10'($urandom);
      d = {$urandom, $urandom};
`ifdef DM_WR_ALIGN_CHECK_EN
      a = a & ~10'(len - 1);
`endif
      send(a, d, dt, busy);
      checks++;
      if (busy != len || obs_a.size() != len) begin
        errors++;
        $display("FAIL rnd%0d_len: busy=%0d n=%0d want %0d",
                 n, busy, obs_a.size(), len);
      end else begin
        for (int k = 0; k < len; k++) begin
          checks++;
          if (obs_a[k] !== exp_addr(a, k) || obs_d[k] !== exp_byte(d, k)
              || obs_c[k] != cap + k) begin
            errors++;
            $display("FAIL rnd%0d_b%0d: got %h@%h want %h@%h", n, k,
                     obs_d[k], obs_a[k], exp_byte(d, k), exp_addr(a, k));
          end
        end
      end
    end
  endtask

`ifdef DM_WR_ALIGN_CHECK_EN
  task automatic test_misaligned();
    int busy;
    logic [63:0] d;
    d = 64'h00000000CAFEF00D;
    send(10'h011, d, 2'b01, busy);
    checks++;
    if (busy != 1) begin
      errors++;
      $display("FAIL mis_busy: got %0d want 1", busy);
    end
    checks++;
    if (obs_a.size() != 0) begin
      errors++;
      $display("FAIL mis_writes: got %0d want 0", obs_a.size());
    end
    checks++;
    if (wr_misaligned !== 1'b1) begin
      errors++;
      $display("FAIL mis_flag: got %b want 1", wr_misaligned);
    end
    send(10'h014, d, 2'b10, busy);
    checks++;
    if (busy != 4 || obs_a.size() != 4) begin
      errors++;
      $display("FAIL mis_next: busy=%0d n=%0d want 4 4", busy, obs_a.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs_a[k] !== exp_addr(10'h014, k) || obs_d[k] !== exp_byte(d, k)) begin
          errors++;
          $display("FAIL mis_next_b%0d: got %h@%h want %h@%h", k,
                   obs_d[k], obs_a[k], exp_byte(d, k), exp_addr(10'h014, k));
        end
      end
    end
    checks++;
    if (wr_misaligned !== 1'b1) begin
      errors++;
      $display("FAIL mis_sticky: got %b want 1", wr_misaligned);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte();
    test_dword_wrap();
    test_back_to_back();
    test_reset_abort();
    test_random();
`ifdef DM_WR_ALIGN_CHECK_EN
    test_misaligned();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_write_handler.md
# dm_write_handler

Data-memory write handler that sits directly downstream of the dual-processor write arbiter and consumes its granted write stream. It accepts one store request (64-bit data bus, byte address, data type) through the `wr_ins` / `wr_idle` handshake. It then serialises the store into little-endian byte writes on a byte-wide SRAM port, one byte per cycle. `wr_idle` is held low for the whole transfer, which is what the arbiter uses to detect acceptance and completion.

## Interface
- `DOUBLEWORD_WIDTH`, default 64, width of the store data bus.
- `DATA_MEMORY_SIZE`, default 1024, memory size in bytes.
- `ADDR_WIDTH_DM`, default `$clog2(DATA_MEMORY_SIZE)`, byte-address width.
- `DATA_TYPE_WIDTH`, default 2, data-type field width.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `data_bus_wr` in `DOUBLEWORD_WIDTH`: store data; bytes are taken from the LSB upward.
- `addr_wr` in `ADDR_WIDTH_DM`: byte address of the first (least significant) byte.
- `data_type_wr` in `DATA_TYPE_WIDTH`: 00 = byte, 01 = halfword, 10 = word, 11 = doubleword.
- `wr_ins` in 1: request strobe.
- `wr_idle` out 1: high when the block can accept a request; low while busy.
- `mem_wr_en` out 1: byte write enable to the SRAM.
- `mem_addr` out `ADDR_WIDTH_DM`: SRAM byte address.
- `mem_wdata` out 8: SRAM write byte.
- `wr_misaligned` out 1: sticky misalignment flag. Present only when `DM_WR_ALIGN_CHECK_EN` is defined.

## Operation
- Reset values:
  - state = IDLE.
  - `wr_idle` = 1, `mem_wr_en` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0.
  - `wr_misaligned` = 0.
  - internal byte counter, length, base address and data shift register all 0.
- States:
  - IDLE. The request is captured at the rising edge where `wr_ins` = 1 in IDLE:
    - base ← `addr_wr`.
    - shift register ← `data_bus_wr`.
    - length ← 2^`data_type_wr` (1/2/4/8).
    - counter ← 0.
    - next state = WRITE (or ERR, see Configuration).
  - WRITE:
    - `mem_wr_en` = 1.
    - `mem_addr` = (base + counter) mod `DATA_MEMORY_SIZE`; the address wraps, so 0x3FF + 1 = 0x000.
    - `mem_wdata` = shift register[7:0].
    - Each cycle the shift register shifts right 8 and the counter increments.
    - When counter = length−1, the next state is IDLE.
  - ERR: one-cycle busy state with no memory write, then IDLE.
- `wr_idle` = 1 only in IDLE; it is a decode of registered state, with no combinational path from `wr_ins`.
- `mem_*` outputs are decoded from registered state, counter and shift register only.
- `wr_ins` is ignored outside IDLE. The master deasserts `wr_ins` after seeing `wr_idle` = 0. If `wr_ins` is still high when the block returns to IDLE, it is taken as a new request.
- Upper data-bus bytes beyond the length are never written.
- Illegal state encodings recover to IDLE with no write.
- `rst_n` asserted mid-transfer aborts immediately: `mem_wr_en` drops asynchronously, remaining bytes are discarded, and the block returns to IDLE on release.

## Timing
- Edge T: request captured.
- Cycles T+1 … T+N: `wr_idle` = 0 and `mem_wr_en` = 1, writing byte k in cycle T+1+k. N = 1/2/4/8.
- Cycle T+N+1: `wr_idle` = 1.
- Latency from request to first byte is 1 cycle. Busy time is N cycles.
- Back-to-back requests: a request present at the IDLE cycle T+N+1 is captured at the end of that cycle. Peak throughput is N bytes per N+1 cycles.
- `wr_idle` falls exactly one cycle after capture, so an arbiter waiting for `~wr_idle` sees the acceptance at T+1 and the release at T+N+1.

## Configuration
- Macro: `DM_WR_ALIGN_CHECK_EN`.
- Defined:
  - A request whose `addr_wr` is not a multiple of its length goes IDLE → ERR → IDLE.
  - `wr_idle` = 0 for exactly one cycle, so the handshake still completes and the arbiter cannot deadlock.
  - No `mem_wr_en`.
  - `wr_misaligned` is set to 1 and held until `rst_n`.
- Not defined:
  - The ERR state and the `wr_misaligned` port are absent.
  - Misaligned requests are written byte-serially with address wrap, like any other request.

## Test plan
- Reset, then check that all outputs take their reset values; `wr_idle` = 1.
- Byte store: `data_type` 00, addr 0x010, data 0x…A5, `wr_ins` for 1 cycle.
  - Expect one write of 0xA5 at 0x010 at T+1, `wr_idle` low for 1 cycle, high at T+2.
- Doubleword store: addr 0x3FC, data 0x8877665544332211, macro undefined.
  - Expect 8 writes, bytes 11,22,…,88, at 0x3FC, 0x3FD, 0x3FE, 0x3FF, 0x000, 0x001, 0x002, 0x003.
  - `wr_idle` low for 8 cycles.
- `wr_ins` held high across a word store at 0x020 with data 0xDEADBEEF.
  - Expect EF,BE,AD,DE at 0x020–0x023, then a second identical transfer starting 1 cycle after `wr_idle` rises.
- `rst_n` pulsed low during byte 3 of a doubleword store.
  - Expect `mem_wr_en` to drop in the same cycle and no further writes after release; `wr_idle` = 1.
- With `DM_WR_ALIGN_CHECK_EN` defined: halfword store at 0x011.
  - Expect `wr_idle` low for exactly 1 cycle, no `mem_wr_en`, and `wr_misaligned` = 1 sticky.
  - A following aligned word store at 0x014 writes normally.
